msx_multi_mapper: RTL and testbench

Clocked, parametrised MegaROM bank mapper for the MSX cartridge slot, succeeding the asynchronous SCC-only ROM mapper. Samples the asynchronous Z80 bus strobes in the FPGA clock domain and holds four 8 KB bank registers. Supports Konami, Konami-SCC, ASCII8 and ASCII16 layouts, selected by a mode pin latched at reset. Drives the upper ROM address bits, the ROM chip select and the SCC register window select.

---
 rtl/msx_multi_mapper.sv | 167 ++++++++++++++++
 tb/tb_msx_multi_mapper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_multi_mapper.sv
`default_nettype none
// ============================================================================
// Module   : msx_multi_mapper
// Purpose  : Clocked MegaROM bank mapper (Konami, Konami-SCC, ASCII8, ASCII16)
//            for the MSX cartridge slot, with synchronised Z80 write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module msx_multi_mapper #(
   parameter int BANK_BITS = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           mode,
   input  logic                 sltsl_n,
   input  logic                 rd_n,
   input  logic                 wr_n,
   input  logic [4:0]           addr,
   input  logic [7:0]           data,
   output logic [BANK_BITS-1:0] rom_addr_hi,
   output logic                 rom_cs_n,
   output logic                 scc_sel,
   output logic                 scc_en
);

   localparam logic [1:0] c_MODE_KONAMI  = 2'd0;
   localparam logic [1:0] c_MODE_SCC     = 2'd1;
   localparam logic [1:0] c_MODE_ASCII8  = 2'd2;
   localparam logic [1:0] c_MODE_ASCII16 = 2'd3;

   logic [1:0]           r_mode;
   logic                 r_run;
   logic                 r_wr_s1;
   logic                 r_wr_s2;
   logic                 r_wr_prev;
   logic [1:0]           r_settle;
   logic                 r_armed;
   logic [BANK_BITS-1:0] r_bank_x [4];
   logic                 r_scc_en;

   logic [BANK_BITS-1:0] w_init [4];
   logic [BANK_BITS-1:0] w_bank [4];
   logic [BANK_BITS-1:0] w_a16_bank;
   logic                 w_wr_event;
   logic                 w_wr_hit;
   logic [1:0]           w_wr_idx;
   logic                 w_wr_commit;
   logic [1:0]           w_page;
   logic                 w_scc_sel;
   logic                 w_unused_data;

   // The mode pin is tracked until the first clock after reset release.
   always_ff @(posedge clk) begin
      if (!r_run) begin
         r_mode <= mode;
      end
   end

   // Banks are stored XOR-ed with their mode-dependent reset value, so a plain
   // clear-to-zero reset yields 0,1,2,3 (Konami) or all zero (ASCII).
   for (genvar i = 0; i < 4; i++) begin : g_bank
      assign w_init[i] = r_mode[1] ? '0 : BANK_BITS'(i);
      assign w_bank[i] = r_bank_x[i] ^ w_init[i];
   end

   // r_armed blocks a strobe that was already low at reset release until it
   // has been seen high through a fully refreshed synchroniser.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run     <= 1'b0;
         r_wr_s1   <= 1'b1;
         r_wr_s2   <= 1'b1;
         r_wr_prev <= 1'b1;
         r_settle  <= 2'b00;
         r_armed   <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_wr_s1   <= wr_n;
         r_wr_s2   <= r_wr_s1;
         r_wr_prev <= r_wr_s2;
         r_settle  <= {r_settle[0], 1'b1};
         if (r_settle[1] && r_wr_s2) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_wr_event = r_armed & r_wr_prev & ~r_wr_s2 & ~sltsl_n;

   always_comb begin
      w_wr_hit = 1'b0;
      w_wr_idx = 2'd0;
      case (r_mode)
         c_MODE_KONAMI: begin
            case (addr[4:2])
               3'b011:  begin w_wr_hit = 1'b1; w_wr_idx = 2'd1; end
               3'b100:  begin w_wr_hit = 1'b1; w_wr_idx = 2'd2; end
               3'b101:  begin w_wr_hit = 1'b1; w_wr_idx = 2'd3; end
               default: ;
            endcase
         end
         c_MODE_SCC: begin
            case (addr)
               5'b01010: begin w_wr_hit = 1'b1; w_wr_idx = 2'd0; end
               5'b01110: begin w_wr_hit = 1'b1; w_wr_idx = 2'd1; end
               5'b10010: begin w_wr_hit = 1'b1; w_wr_idx = 2'd2; end
               5'b10110: begin w_wr_hit = 1'b1; w_wr_idx = 2'd3; end
               default:  ;
            endcase
         end
         c_MODE_ASCII8: begin
            if (addr[4:2] == 3'b011) begin
               w_wr_hit = 1'b1;
               w_wr_idx = addr[1:0];
            end
         end
         c_MODE_ASCII16: begin
            if (addr == 5'b01100) begin
               w_wr_hit = 1'b1;
               w_wr_idx = 2'd0;
            end else if (addr == 5'b01110) begin
               w_wr_hit = 1'b1;
               w_wr_idx = 2'd2;
            end
         end
         default: ;
      endcase
   end

   assign w_wr_commit = w_wr_event & w_wr_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            r_bank_x[i] <= '0;
         end
         r_scc_en <= 1'b0;
      end else if (w_wr_commit) begin
         r_bank_x[w_wr_idx] <= data[BANK_BITS-1:0] ^ w_init[w_wr_idx];
         if (r_mode == c_MODE_SCC && w_wr_idx == 2'd2) begin
            r_scc_en <= (data[5:0] == 6'h3F);
         end
      end
   end

   // Page index: 4000h->0, 6000h->1, 8000h->2, A000h->3 (mirrored elsewhere).
   assign w_page     = {~addr[3], addr[2]};
   assign w_a16_bank = addr[3] ? w_bank[0] : w_bank[2];

   always_comb begin
      if (r_mode == c_MODE_ASCII16) begin
         rom_addr_hi = {w_a16_bank[BANK_BITS-2:0], addr[2]};
      end else begin
         rom_addr_hi = w_bank[w_page];
      end
   end

   assign w_scc_sel = (r_mode == c_MODE_SCC) & r_scc_en & ~sltsl_n &
                      (addr == 5'b10011);

   assign scc_sel  = w_scc_sel;
   assign scc_en   = r_scc_en;
   assign rom_cs_n = ~(~sltsl_n & ~rd_n & (addr[4] ^ addr[3]) & ~w_scc_sel);

   assign w_unused_data = ^data;

endmodule
`default_nettype wire

// File: tb/tb_msx_multi_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_msx_multi_mapper
// Purpose  : Directed, table-driven self-checking bench for msx_multi_mapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_multi_mapper;

   localparam int BANK_BITS = 6;
   localparam int OP_RST = 0;
   localparam int OP_WR  = 1;
   localparam int OP_RD  = 2;

   typedef struct {
      int          op;
      logic [1:0]  mode;
      logic [15:0] a;
      logic [7:0]  d;
      logic        sl;
      logic        rd;
      logic [5:0]  page;
      logic        cs_n;
      logic        sel;
      logic        en;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [1:0]           mode = 2'd0;
   logic                 sltsl_n = 1'b1;
   logic                 rd_n = 1'b1;
   logic                 wr_n = 1'b1;
   logic [4:0]           addr = 5'd0;
   logic [7:0]           data = 8'd0;
   logic [BANK_BITS-1:0] rom_addr_hi;
   logic                 rom_cs_n;
   logic                 scc_sel;
   logic                 scc_en;

   int   n_checks = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   msx_multi_mapper #(.BANK_BITS(BANK_BITS)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode        (mode),
      .sltsl_n     (sltsl_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .addr        (addr),
      .data        (data),
      .rom_addr_hi (rom_addr_hi),
      .rom_cs_n    (rom_cs_n),
      .scc_sel     (scc_sel),
      .scc_en      (scc_en)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_rst(input logic [1:0] m);
      vec_t v;
      v = '{op: OP_RST, mode: m, a: 16'h0, d: 8'h0, sl: 1'b1, rd: 1'b1,
            page: 6'h0, cs_n: 1'b1, sel: 1'b0, en: 1'b0};
      vecs.push_back(v);
   endtask

   task automatic add_wr(input logic [15:0] a, input logic [7:0] d, input logic sl);
      vec_t v;
      v = '{op: OP_WR, mode: 2'd0, a: a, d: d, sl: sl, rd: 1'b1,
            page: 6'h0, cs_n: 1'b1, sel: 1'b0, en: 1'b0};
      vecs.push_back(v);
   endtask

   task automatic add_rd(input logic [15:0] a, input logic sl, input logic rd,
                         input logic [5:0] pg, input logic cs, input logic sel,
                         input logic en);
      vec_t v;
      v = '{op: OP_RD, mode: 2'd0, a: a, d: 8'h0, sl: sl, rd: rd,
            page: pg, cs_n: cs, sel: sel, en: en};
      vecs.push_back(v);
   endtask

   task automatic do_reset(input logic [1:0] m);
      @(posedge clk); #1;
      wr_n = 1'b1; rd_n = 1'b1; sltsl_n = 1'b1;
      reset_n = 1'b0;
      mode = m;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic sl);
      @(posedge clk); #1;
      addr = a[15:11]; data = d; sltsl_n = sl; wr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 wr_n = 1'b1; sltsl_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_read(input string tag, input vec_t v);
      addr = v.a[15:11]; sltsl_n = v.sl; rd_n = v.rd;
      #2;
      check({tag, "_page"}, int'(rom_addr_hi), int'(v.page));
      check({tag, "_cs_n"}, int'(rom_cs_n), int'(v.cs_n));
      check({tag, "_sel"},  int'(scc_sel),  int'(v.sel));
      check({tag, "_en"},   int'(scc_en),   int'(v.en));
      rd_n = 1'b1; sltsl_n = 1'b1;
   endtask

   task automatic read_page(input string tag, input logic [15:0] a, input logic [5:0] pg);
      addr = a[15:11]; sltsl_n = 1'b0; rd_n = 1'b0;
      #2;
      check(tag, int'(rom_addr_hi), int'(pg));
      rd_n = 1'b1; sltsl_n = 1'b1;
   endtask

   initial begin
      // Konami
      add_rst(2'd0);
      add_rd(16'h4000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h01, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h02, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h03, 0, 0, 0);
      add_wr(16'h6000, 8'h15, 0);
      add_wr(16'h8000, 8'h2A, 0);
      add_wr(16'hA000, 8'hFF, 0);
      add_wr(16'h4000, 8'h11, 0);
      add_wr(16'h5000, 8'h22, 0);
      add_rd(16'h4000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h15, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h2A, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h3F, 0, 0, 0);
      add_rd(16'h2000, 0, 0, 6'h3F, 1, 0, 0);
      add_wr(16'h9000, 8'h3F, 0);
      add_rd(16'h9800, 0, 0, 6'h3F, 0, 0, 0);
      // Konami-SCC
      add_rst(2'd1);
      add_rd(16'h4000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h01, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h02, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h03, 0, 0, 0);
      add_rd(16'h9800, 0, 0, 6'h02, 0, 0, 0);
      add_wr(16'h5000, 8'h0A, 0);
      add_wr(16'h7000, 8'h0B, 0);
      add_wr(16'h9000, 8'h3F, 0);
      add_wr(16'hB000, 8'h0D, 0);
      add_wr(16'h6000, 8'h22, 0);
      add_wr(16'h5800, 8'h33, 0);
      add_rd(16'h4000, 0, 0, 6'h0A, 0, 0, 1);
      add_rd(16'h6000, 0, 0, 6'h0B, 0, 0, 1);
      add_rd(16'h8000, 0, 0, 6'h3F, 0, 0, 1);
      add_rd(16'hA000, 0, 0, 6'h0D, 0, 0, 1);
      add_rd(16'h9800, 0, 0, 6'h3F, 1, 1, 1);
      add_rd(16'h9800, 1, 0, 6'h3F, 1, 0, 1);
      add_rd(16'h9800, 0, 1, 6'h3F, 1, 1, 1);
      add_wr(16'h5000, 8'h01, 1);
      add_rd(16'h4000, 0, 0, 6'h0A, 0, 0, 1);
      add_wr(16'h9000, 8'h05, 0);
      add_rd(16'h8000, 0, 0, 6'h05, 0, 0, 0);
      add_rd(16'h9800, 0, 0, 6'h05, 0, 0, 0);
      add_wr(16'h9000, 8'h7F, 0);
      add_rd(16'h8000, 0, 0, 6'h3F, 0, 0, 1);
      // ASCII8
      add_rst(2'd2);
      add_rd(16'h4000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h00, 0, 0, 0);
      add_wr(16'h6000, 8'h01, 0);
      add_wr(16'h6800, 8'h02, 0);
      add_wr(16'h7000, 8'h03, 0);
      add_wr(16'h7800, 8'h04, 0);
      add_wr(16'h8000, 8'h09, 0);
      add_wr(16'h5000, 8'h0A, 0);
      add_rd(16'h4000, 0, 0, 6'h01, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h02, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h03, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h04, 0, 0, 0);
      add_rd(16'hC000, 0, 0, 6'h01, 1, 0, 0);
      // ASCII16
      add_rst(2'd3);
      add_rd(16'h4000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h01, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h00, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h01, 0, 0, 0);
      add_wr(16'h6000, 8'h07, 0);
      add_wr(16'h7000, 8'h03, 0);
      add_rd(16'h4000, 0, 0, 6'h0E, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h0F, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h06, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h07, 0, 0, 0);
      add_wr(16'h6800, 8'h3F, 0);
      add_wr(16'h7800, 8'h3F, 0);
      add_rd(16'h4000, 0, 0, 6'h0E, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h0F, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h06, 0, 0, 0);
      add_rd(16'hA000, 0, 0, 6'h07, 0, 0, 0);
      add_wr(16'h6000, 8'h11, 1);
      add_wr(16'h7000, 8'h12, 1);
      add_rd(16'h4000, 0, 0, 6'h0E, 0, 0, 0);
      add_rd(16'h8000, 0, 0, 6'h06, 0, 0, 0);
      add_rd(16'h4000, 1, 0, 6'h0E, 1, 0, 0);
      add_rd(16'h8000, 1, 0, 6'h06, 1, 0, 0);
      add_wr(16'h6000, 8'h3F, 0);
      add_rd(16'h4000, 0, 0, 6'h3E, 0, 0, 0);
      add_rd(16'h6000, 0, 0, 6'h3F, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_RST:  do_reset(vecs[i].mode);
            OP_WR:   do_write(vecs[i].a, vecs[i].d, vecs[i].sl);
            default: do_read($sformatf("vec%0d", i), vecs[i]);
         endcase
      end

      // Write latency and single write per held-low strobe (ASCII8, bank1 @6800)
      do_reset(2'd2);
      @(posedge clk); #1;
      addr = 5'b01101; data = 8'h2C; sltsl_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      #1 check("rdwr_cs_n", int'(rom_cs_n), 0);
      @(posedge clk); #1 check("lat_e1", int'(rom_addr_hi), 'h00);
      @(posedge clk); #1 check("lat_e2", int'(rom_addr_hi), 'h00);
      @(posedge clk); #1 check("lat_e3", int'(rom_addr_hi), 'h2C);
      data = 8'h11;
      repeat (17) @(posedge clk);
      #1 check("held_once", int'(rom_addr_hi), 'h2C);
      wr_n = 1'b1; rd_n = 1'b1; sltsl_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 read_page("held_after", 16'h6800, 6'h2C);

      // Reset in the middle of a write, with a mode change to Konami
      @(posedge clk); #1;
      mode = 2'd0; addr = 5'b01101; data = 8'h3A; sltsl_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b0;
      #1 check("rst_async", int'(rom_addr_hi), 'h00);
      repeat (3) @(posedge clk);
      #1 check("rst_mode", int'(rom_addr_hi), 'h01);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("rst_nowr", int'(rom_addr_hi), 'h01);
      wr_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("rst_rise", int'(rom_addr_hi), 'h01);
      wr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("rst_rewr", int'(rom_addr_hi), 'h3A);
      wr_n = 1'b1; sltsl_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 read_page("rst_b3", 16'hA000, 6'h03);
      read_page("rst_b0", 16'h4000, 6'h00);
      check("rst_scc_en", int'(scc_en), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
